// File: rtl/vga_scanout_800x600.sv
// Framebuffer scanout for the 800x600 timing generator: pixel-replicated upscale, aligned syncs,
// and a vblank-synchronous bank swap. Define SCANOUT_TEST_PATTERN_EN to add the colour-bar test pattern.
module vga_scanout_800x600 #(
  parameter int unsigned DISPLAY_WIDTH  = 800,
  parameter int unsigned DISPLAY_HEIGHT = 600,
  parameter int unsigned FB_WIDTH       = 200,
  parameter int unsigned FB_HEIGHT      = 150,
  parameter int unsigned SCALE_SHIFT    = 2,
  parameter int unsigned BRAM_LATENCY   = 2,
  parameter int unsigned ADDR_W         = $clog2(FB_WIDTH * FB_HEIGHT)
) (
  input  logic              pixel_clk_in,
  input  logic              rst_in,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              blank_in,
`ifdef SCANOUT_TEST_PATTERN_EN
  input  logic              pattern_sel_in,
`endif
  output logic [ADDR_W-1:0] rd_addr_out,
  output logic              rd_bank_out,
  input  logic [11:0]       rd_data_in,
  input  logic              swap_req_in,
  output logic              swap_ack_out,
  output logic              frame_start_out,
  output logic [3:0]        red_out,
  output logic [3:0]        green_out,
  output logic [3:0]        blue_out,
  output logic              hsync_out,
  output logic              vsync_out
);

  localparam int unsigned LAT   = BRAM_LATENCY + 2;
  localparam int unsigned HC_W  = 11;
  localparam int unsigned VC_W  = 10;
  localparam int unsigned FX_W  = HC_W - SCALE_SHIFT;
  localparam int unsigned FY_W  = VC_W - SCALE_SHIFT;
  localparam int unsigned LIN_W = FY_W + $clog2(FB_WIDTH + 1) + 1;

  logic [FX_W-1:0]   fx_c;
  logic [FY_W-1:0]   fy_c;
  logic              oob_c;
  logic              event_c;
  logic [LIN_W-1:0]  lin_c;

  logic [ADDR_W-1:0] addr_d, addr_q;
  logic              bank_d, bank_q;
  logic              ack_d, ack_q;
  logic              fs_d, fs_q;
  logic [11:0]       rgb_d, rgb_q;
  logic [LAT-1:0]    hs_d, hs_q;
  logic [LAT-1:0]    vs_d, vs_q;
  logic [LAT-1:0]    bl_d, bl_q;
  logic [LAT-1:0]    oob_d, oob_q;

  // Stage 0: framebuffer coordinate, bounds test and linear address.
  always_comb begin
    fx_c    = FX_W'(hcount_in >> SCALE_SHIFT);
    fy_c    = FY_W'(vcount_in >> SCALE_SHIFT);
    oob_c   = blank_in
            | (hcount_in >= HC_W'(DISPLAY_WIDTH))
            | (vcount_in >= VC_W'(DISPLAY_HEIGHT))
            | (fx_c >= FX_W'(FB_WIDTH))
            | (fy_c >= FY_W'(FB_HEIGHT));
    lin_c   = LIN_W'(fy_c) * LIN_W'(FB_WIDTH) + LIN_W'(fx_c);
    addr_d  = oob_c ? '0 : ADDR_W'(lin_c);
    event_c = (hcount_in == '0) && (vcount_in == VC_W'(DISPLAY_HEIGHT));
  end

  // Frame-start pulse and bank swap, both fired on the first vblank line.
  always_comb begin
    fs_d   = event_c;
    ack_d  = event_c & swap_req_in;
    bank_d = bank_q ^ ack_d;
  end

  // Timing delay lines; stage LAT-2 qualifies the data arriving from the BRAM.
  always_comb begin
    hs_d  = {hs_q[LAT-2:0], hsync_in};
    vs_d  = {vs_q[LAT-2:0], vsync_in};
    bl_d  = {bl_q[LAT-2:0], blank_in};
    oob_d = {oob_q[LAT-2:0], oob_c};
  end

`ifdef SCANOUT_TEST_PATTERN_EN
  localparam logic [9:0] BAR_W = 10'(DISPLAY_WIDTH / 8);

  logic [LAT-2:0][9:0] hc_d, hc_q;
  logic [LAT-2:0]      psel_d, psel_q;
  logic [9:0]          bar_c;
  logic [11:0]         bar_rgb_c;

  always_comb begin
    hc_d   = {hc_q[LAT-3:0], hcount_in[9:0]};
    psel_d = {psel_q[LAT-3:0], pattern_sel_in};
  end

  // Eight 100-pixel bars; anything past the eighth bar stays black.
  always_comb begin
    bar_c = hc_q[LAT-2] / BAR_W;
    case (bar_c)
      10'd0:   bar_rgb_c = 12'hFFF;
      10'd1:   bar_rgb_c = 12'hFF0;
      10'd2:   bar_rgb_c = 12'h0FF;
      10'd3:   bar_rgb_c = 12'h0F0;
      10'd4:   bar_rgb_c = 12'hF0F;
      10'd5:   bar_rgb_c = 12'hF00;
      10'd6:   bar_rgb_c = 12'h00F;
      default: bar_rgb_c = 12'h000;
    endcase
  end

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      hc_q   <= '0;
      psel_q <= '0;
    end else begin
      hc_q   <= hc_d;
      psel_q <= psel_d;
    end
  end
`endif

  always_comb begin
    rgb_d = rd_data_in;
`ifdef SCANOUT_TEST_PATTERN_EN
    if (psel_q[LAT-2]) begin
      rgb_d = bar_rgb_c;
    end
`endif
    if (bl_q[LAT-2] | oob_q[LAT-2]) begin
      rgb_d = '0;
    end
  end

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      addr_q <= '0;
      bank_q <= 1'b0;
      ack_q  <= 1'b0;
      fs_q   <= 1'b0;
      rgb_q  <= '0;
      hs_q   <= '1;
      vs_q   <= '1;
      bl_q   <= '1;
      oob_q  <= '1;
    end else begin
      addr_q <= addr_d;
      bank_q <= bank_d;
      ack_q  <= ack_d;
      fs_q   <= fs_d;
      rgb_q  <= rgb_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      bl_q   <= bl_d;
      oob_q  <= oob_d;
    end
  end

  assign rd_addr_out     = addr_q;
  assign rd_bank_out     = bank_q;
  assign swap_ack_out    = ack_q;
  assign frame_start_out = fs_q;
  assign red_out         = rgb_q[11:8];
  assign green_out       = rgb_q[7:4];
  assign blue_out        = rgb_q[3:0];
  assign hsync_out       = hs_q[LAT-1];
  assign vsync_out       = vs_q[LAT-1];

endmodule
